// File: rtl/bw_tlb_miss_walker_pkg.sv
// Shared MMU types: PTE / TLBE layout, walker state encoding and fault causes.
// A PTE is the lower 128-bit half of a TLBE.
package bw_tlb_miss_walker_pkg;

    typedef struct packed {
        logic [31:0] adr;           // [127:96] address the PTE was fetched from
        logic [15:0] access_count;  // [95:80]
        logic [7:0]  asid;          // [79:72]
        logic [39:0] rsvd;          // [71:32]
        logic [15:0] ppn;           // [31:16]
        logic [13:0] flags;         // [15:2]
        logic        g;             // [1] global: keep the PTE's own asid
        logic        v;             // [0]
    } pte_t;

    typedef struct packed {
        logic [127:0] ext;
        pte_t         pte;
    } tlbe_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_CHECK,
        S_WRITE,
        S_DRAIN,
        S_FAULT
    } walk_state_e;

    localparam logic [1:0] CAUSE_INVALID = 2'd0;
    localparam logic [1:0] CAUSE_BUSERR  = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    function automatic tlbe_t mk_tlbe(input pte_t p, input logic [7:0] asid, input logic [31:0] adr);
        tlbe_t t;
        t.ext              = '0;
        t.pte              = p;
        t.pte.access_count = '0;
        t.pte.adr          = adr;
        if (!p.g) t.pte.asid = asid;
        return t;
    endfunction

endpackage

// File: rtl/bw_walker_timeout.sv
// Loadable up-counter that saturates at TMO and flags the terminal count.
module bw_walker_timeout #(
    parameter int TMO = 1023
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic tc_o
);
    localparam int W = (TMO < 2) ? 1 : $clog2(TMO + 1);

    logic [W-1:0] cnt_q;

    assign tc_o = (cnt_q == W'(TMO));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               cnt_q <= '0;
        else if (load_i)         cnt_q <= '0;
        else if (en_i && !tc_o)  cnt_q <= cnt_q + W'(1);
    end
endmodule

// File: rtl/bw_tlb_miss_walker.sv
// TLB refill sequencer: fetch one PTE from a single-level table, then write a
// TLBE into a round-robin way, or raise a page fault on invalid PTE / bus error / timeout.
module bw_tlb_miss_walker
    import bw_tlb_miss_walker_pkg::*;
#(
    parameter int ASSOC     = 5,
    parameter int TMO       = 1023,
    parameter int PTE_BYTES = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         tlbmiss_i,
    input  logic [31:0]  tlbmiss_adr_i,
    input  logic [7:0]   asid_i,
    input  logic [31:0]  ptbr_i,
    input  logic         tlb_rdy_i,
    output logic         m_cyc_o,
    output logic         m_stb_o,
    output logic [31:0]  m_adr_o,
    input  logic         m_ack_i,
    input  logic         m_err_i,
    input  logic [127:0] m_dat_i,
    output logic         wrtlb_o,
    output logic [15:0]  tlbadr_o,
    output tlbe_t        tlbdat_o,
    output logic         busy_o,
    output logic         fault_o,
    output logic [1:0]   fault_cause_o,
    output logic [31:0]  fault_adr_o
);
    walk_state_e state_q, state_d;
    logic [31:0] va_q, va_d;
    logic [31:0] adr_q, adr_d;
    logic [7:0]  asid_q, asid_d;
    tlbe_t       tlbe_q, tlbe_d;
    logic [2:0]  way_q, way_d;
    logic [1:0]  cause_q, cause_d;
    logic        tmo_load, tmo_en, tmo_tc;

    bw_walker_timeout #(.TMO(TMO)) u_tmo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .load_i (tmo_load),
        .en_i   (tmo_en),
        .tc_o   (tmo_tc)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            va_q    <= '0;
            adr_q   <= '0;
            asid_q  <= '0;
            tlbe_q  <= '0;
            way_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            va_q    <= va_d;
            adr_q   <= adr_d;
            asid_q  <= asid_d;
            tlbe_q  <= tlbe_d;
            way_q   <= way_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        va_d     = va_q;
        adr_d    = adr_q;
        asid_d   = asid_q;
        tlbe_d   = tlbe_q;
        way_d    = way_q;
        cause_d  = cause_q;
        tmo_load = 1'b0;
        tmo_en   = 1'b0;
        wrtlb_o  = 1'b0;
        fault_o  = 1'b0;
        unique case (state_q)
            S_IDLE: if (tlbmiss_i) begin
                va_d    = tlbmiss_adr_i;
                asid_d  = asid_i;
                adr_d   = ptbr_i + 32'(PTE_BYTES) * {16'h0, tlbmiss_adr_i[31:16]};
                state_d = S_REQ;
            end
            S_REQ: begin
                tmo_load = 1'b1;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                tmo_en = 1'b1;
                // err beats a simultaneous ack; ack beats an expiring timer
                if (m_err_i) begin
                    cause_d = CAUSE_BUSERR;
                    state_d = S_FAULT;
                end else if (m_ack_i) begin
                    tlbe_d  = mk_tlbe(pte_t'(m_dat_i), asid_q, adr_q);
                    state_d = S_CHECK;
                end else if (tmo_tc) begin
                    cause_d = CAUSE_TIMEOUT;
                    state_d = S_FAULT;
                end
            end
            S_CHECK: begin
                if (!tlbe_q.pte.v) begin
                    cause_d = CAUSE_INVALID;
                    state_d = S_FAULT;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: if (tlb_rdy_i) begin
                wrtlb_o = 1'b1;
                way_d   = (way_q == 3'(ASSOC - 2)) ? 3'd0 : way_q + 3'd1;
                state_d = S_DRAIN;
            end
            S_FAULT: begin
                fault_o = 1'b1;
                state_d = S_DRAIN;
            end
            S_DRAIN: if (!tlbmiss_i || (tlbmiss_adr_i[31:16] != va_q[31:16])) begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_cyc_o       = (state_q == S_REQ) || (state_q == S_WAIT);
    assign m_stb_o       = m_cyc_o;
    assign m_adr_o       = adr_q;
    assign tlbadr_o      = {1'b0, va_q[25:16], 2'b00, way_q};
    assign tlbdat_o      = tlbe_q;
    assign busy_o        = (state_q != S_IDLE);
    assign fault_cause_o = cause_q;
    assign fault_adr_o   = va_q;

endmodule

// File: tb/tb_bw_tlb_miss_walker.sv
// Scoreboard bench for the TLB miss walker: stimulus queues expected refills/faults,
// a negedge monitor pops and compares whenever wrtlb_o or fault_o fires.
module tb_bw_tlb_miss_walker;
    import bw_tlb_miss_walker_pkg::*;

    localparam int ASSOC = 5;
    localparam int TMO   = 1023;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         tlbmiss_i = 1'b0;
    logic [31:0]  tlbmiss_adr_i = '0;
    logic [7:0]   asid_i = '0;
    logic [31:0]  ptbr_i = '0;
    logic         tlb_rdy_i = 1'b1;
    logic         m_cyc_o, m_stb_o;
    logic [31:0]  m_adr_o;
    logic         m_ack_i = 1'b0;
    logic         m_err_i = 1'b0;
    logic [127:0] m_dat_i = '0;
    logic         wrtlb_o;
    logic [15:0]  tlbadr_o;
    tlbe_t        tlbdat_o;
    logic         busy_o, fault_o;
    logic [1:0]   fault_cause_o;
    logic [31:0]  fault_adr_o;

    bw_tlb_miss_walker #(.ASSOC(ASSOC), .TMO(TMO), .PTE_BYTES(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tlbmiss_i(tlbmiss_i), .tlbmiss_adr_i(tlbmiss_adr_i),
        .asid_i(asid_i), .ptbr_i(ptbr_i), .tlb_rdy_i(tlb_rdy_i), .m_cyc_o(m_cyc_o),
        .m_stb_o(m_stb_o), .m_adr_o(m_adr_o), .m_ack_i(m_ack_i), .m_err_i(m_err_i),
        .m_dat_i(m_dat_i), .wrtlb_o(wrtlb_o), .tlbadr_o(tlbadr_o), .tlbdat_o(tlbdat_o),
        .busy_o(busy_o), .fault_o(fault_o), .fault_cause_o(fault_cause_o), .fault_adr_o(fault_adr_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit           is_fault;
        logic [1:0]   cause;
        logic [31:0]  fadr;
        logic [15:0]  tadr;
        logic [255:0] tdat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0, n_bad = 0, walks = 0, exp_way = 0;
    logic busy_prev = 1'b0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    // Reference: PTE address is base + page number * 16; ways cycle over the ASSOC-1 writable ways.
    function automatic exp_t model(input logic [31:0] va, input logic [7:0] asid,
                                   input logic [31:0] ptbr, input int kind, input logic [127:0] dat);
        exp_t e;
        pte_t p;
        p          = dat;
        e.fadr     = va;
        e.tadr     = {1'b0, va[25:16], 2'b00, 3'(exp_way)};
        e.is_fault = 1'b1;
        e.cause    = 2'd0;
        if (kind == 1 || kind == 2) e.cause = 2'd1;
        else if (kind == 3)         e.cause = 2'd2;
        else if (p.v)               e.is_fault = 1'b0;
        p.adr          = ptbr + 32'(va[31:16]) * 32'd16;
        p.access_count = '0;
        if (!p.g) p.asid = asid;
        e.tdat = {128'h0, p};
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            busy_prev <= 1'b0;
        end else begin
            exp_t e;
            if (busy_o && !busy_prev) walks++;
            if (wrtlb_o || fault_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {wrtlb_o, fault_o}, 2'b00);
                end else begin
                    e = sb.pop_front();
                    chk("event_fault", fault_o, e.is_fault);
                    chk("event_wrtlb", wrtlb_o, !e.is_fault);
                    if (e.is_fault) begin
                        chk("fault_cause", fault_cause_o, e.cause);
                        chk("fault_adr", fault_adr_o, e.fadr);
                    end else begin
                        chk("tlbadr", tlbadr_o, e.tadr);
                        chk("tlbdat", tlbdat_o, e.tdat);
                    end
                end
            end
            busy_prev <= busy_o;
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout)
    task automatic walk(input logic [31:0] va, input logic [7:0] asid, input int kind, input int dly,
                        input logic [127:0] dat, input int rdy_lo, input int hold, input bit drop);
        exp_t e;
        int   w0, n;
        e = model(va, asid, ptbr_i, kind, dat);
        sb.push_back(e);
        if (!e.is_fault) exp_way = (exp_way + 1) % (ASSOC - 1);
        w0 = walks;
        tlb_rdy_i = (rdy_lo == 0);
        tlbmiss_i = 1'b1; tlbmiss_adr_i = va; asid_i = asid;
        n = 0;
        while (!m_cyc_o && n < 20) begin tick(); n++; end
        chk("m_cyc_start", m_cyc_o, 1'b1);
        chk("m_adr", m_adr_o, ptbr_i + 32'(va[31:16]) * 32'd16);
        tick();
        if (kind == 3) begin
            n = 0;
            while (!fault_o && n < TMO + 50) begin tick(); n++; end
            n_cmp++;
            if (n < TMO || n > TMO + 2) begin
                n_bad++;
                $display("FAIL timeout_cycles: got %0d expected %0d..%0d", n, TMO, TMO + 2);
            end
            chk("m_cyc_after_tmo", m_cyc_o, 1'b0);
        end else begin
            repeat (dly) tick();
            m_ack_i = (kind == 0 || kind == 2);
            m_err_i = (kind == 1 || kind == 2);
            m_dat_i = dat;
            tick();
            m_ack_i = 1'b0; m_err_i = 1'b0; m_dat_i = {4{$urandom()}};
            chk("m_cyc_dropped", m_cyc_o, 1'b0);
            if (!e.is_fault) begin
                for (int i = 0; i < rdy_lo; i++) begin
                    tick();
                    chk("bp_wrtlb_held", wrtlb_o, 1'b0);
                    chk("bp_tlbadr_stable", tlbadr_o, e.tadr);
                    chk("bp_tlbdat_stable", tlbdat_o, e.tdat);
                end
            end
            tlb_rdy_i = 1'b1;
        end
        repeat (hold + 3) tick();
        chk("drain_holds_busy", busy_o, 1'b1);
        chk("walks_per_miss", walks - w0, 1);
        chk("sb_empty", sb.size(), 0);
        if (drop) begin
            tlbmiss_i = 1'b0;
            n = 0;
            while (busy_o && n < 10) begin tick(); n++; end
            chk("idle_after_drain", busy_o, 1'b0);
        end
    endtask

    function automatic logic [127:0] pte_of(input logic [15:0] ppn, input bit v);
        pte_t p;
        p     = {4{$urandom()}};
        p.ppn = ppn;
        p.v   = v;
        return p;
    endfunction

    initial begin
        logic [127:0] d;
        int r, kind;
        #3;
        chk("rst_m_cyc", m_cyc_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_wrtlb", wrtlb_o, 1'b0);
        chk("rst_fault", fault_o, 1'b0);
        chk("rst_tlbadr", tlbadr_o, 16'h0);
        chk("rst_tlbdat", tlbdat_o, 256'h0);
        chk("rst_m_adr", m_adr_o, 32'h0);
        tick();
        rst_i = 1'b0;
        tick();

        // basic refill
        ptbr_i = 32'h0010_0000;
        walk(32'h1234_5678, 8'h5A, 0, 3, pte_of(16'h00AB, 1'b1), 0, 2, 1'b1);
        chk("basic_ppn", tlbdat_o.pte.ppn, 16'h00AB);
        chk("basic_pte_adr", tlbdat_o.pte.adr, 32'h0011_2340);
        chk("basic_set", tlbadr_o[14:5], 10'h234);

        // invalid PTE, bus error, ack+err, timeout
        walk(32'h0BAD_0000, 8'h11, 0, 1, pte_of(16'h0001, 1'b0), 0, 1, 1'b1);
        walk(32'h2222_0004, 8'h22, 1, 1, pte_of(16'h0002, 1'b1), 0, 1, 1'b1);
        walk(32'h3333_0008, 8'h33, 2, 0, pte_of(16'h0003, 1'b1), 0, 1, 1'b1);
        walk(32'h4444_000C, 8'h44, 3, 0, '0, 0, 1, 1'b1);

        // async reset mid-WAIT, way counter returns to 0
        tlbmiss_i = 1'b1; tlbmiss_adr_i = 32'h5555_0000;
        r = 0;
        while (!m_cyc_o && r < 20) begin tick(); r++; end
        tick();
        #2 rst_i = 1'b1;
        #1;
        chk("arst_m_cyc", m_cyc_o, 1'b0);
        chk("arst_busy", busy_o, 1'b0);
        chk("arst_wrtlb", wrtlb_o, 1'b0);
        tlbmiss_i = 1'b0;
        tick();
        rst_i = 1'b0;
        exp_way = 0;
        tick();

        // way rotation over five distinct pages
        for (int i = 0; i < 5; i++)
            walk({16'h6000 + 16'(i), 16'h0}, 8'(i), 0, i % 3, pte_of(16'(i), 1'b1), 0, 0, 1'b1);

        // back-pressure, then miss held on one page followed by a new page
        walk(32'h7777_1000, 8'h77, 0, 2, pte_of(16'h0777, 1'b1), 6, 1, 1'b1);
        walk(32'h8888_2000, 8'h88, 0, 0, pte_of(16'h0888, 1'b1), 0, 12, 1'b0);
        walk(32'h9999_3000, 8'h99, 0, 1, pte_of(16'h0999, 1'b1), 1, 2, 1'b1);

        for (int k = 0; k < 30; k++) begin
            r    = $urandom_range(0, 9);
            kind = (r == 7) ? 1 : (r == 8) ? 2 : 0;
            d    = {4{$urandom()}};
            d[0] = (r != 9);
            ptbr_i = $urandom() & 32'hFFFF_FFF0;
            walk($urandom(), 8'($urandom()), kind, $urandom_range(0, 4), d,
                 $urandom_range(0, 3), $urandom_range(0, 5), 1'b1);
        end

        repeat (3) tick();
        chk("final_sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
